// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, receiver FSM states and baud divider helpers shared by the UART blocks
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + baud * oversample / 2) / (baud * oversample);
  endfunction
  function automatic int div_width(input int clk_freq, input int baud, input int oversample);
    int d;
    d = baud_div(clk_freq, baud, oversample);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle oversample tick every DIV clocks, restartable to phase-align on a start edge
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  import uart_pkg::*;
  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int W   = div_width(CLK_FREQ, BAUD, OVERSAMPLE);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= (restart || cnt == W'(DIV - 1)) ? '0 : cnt + W'(1);
  end
  assign tick = !restart && cnt == W'(DIV - 1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority vote, parity/framing/overrun reporting and valid/ready output
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  import uart_pkg::*;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  state_t state, state_n;
  logic s1, rxd_s, rxd_q;
  logic [1:0] samp;
  logic [SW-1:0] scnt;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  logic pend_pe, pend_fe;
  logic tick, restart, fall, decide, bit_end, vote, last_data, last_stop, complete, par_bad, take, load;
  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst(rst), .restart(restart), .tick(tick)
  );
  assign fall      = rxd_q && !rxd_s;
  assign decide    = tick && scnt == SW'(MID + 1);
  assign bit_end   = tick && scnt == SW'(OVERSAMPLE - 1);
  assign vote      = (samp[1] & samp[0]) | (samp[1] & rxd_s) | (samp[0] & rxd_s);
  assign last_data = bcnt == 4'(DATA_BITS - 1);
  assign last_stop = bcnt == 4'(STOP_BITS - 1);
  assign restart   = state == IDLE && fall;
  assign complete  = state == STOP && decide && last_stop;
  assign par_bad   = (^sh ^ vote) != (PARITY == PAR_ODD);
  assign take      = !rx_valid || rx_ready;
  assign load      = complete && take;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:             state_n = fall ? START : IDLE;
      START:            state_n = (decide && vote) ? IDLE : bit_end ? DATA : START;
      DATA:             state_n = (bit_end && last_data) ? (PARITY != PAR_NONE ? uart_pkg::PARITY : STOP) : DATA;
      uart_pkg::PARITY: state_n = bit_end ? STOP : uart_pkg::PARITY;
      STOP:             state_n = complete ? (vote ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH:        state_n = rxd_s ? IDLE : WAIT_HIGH;
      default:          state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s1      <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_q   <= 1'b1;
      samp    <= '1;
      scnt    <= '0;
      bcnt    <= '0;
      sh      <= '0;
      pend_pe <= 1'b0;
      pend_fe <= 1'b0;
    end else begin
      state   <= state_n;
      s1      <= uart_rxd;
      rxd_s   <= s1;
      rxd_q   <= rxd_s;
      samp    <= tick ? {samp[0], rxd_s} : samp;
      scnt    <= state == IDLE ? '0 : tick ? (scnt == SW'(OVERSAMPLE - 1) ? '0 : scnt + SW'(1)) : scnt;
      bcnt    <= state != state_n ? '0 : bit_end ? bcnt + 4'd1 : bcnt;
      sh      <= (state == DATA && decide) ? {vote, sh[DATA_BITS-1:1]} : sh;
      pend_pe <= state == IDLE ? 1'b0 : (state == uart_pkg::PARITY && decide) ? par_bad : pend_pe;
      pend_fe <= state == IDLE ? 1'b0 : (state == STOP && decide && !vote) ? 1'b1 : pend_fe;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_data    <= load ? sh : rx_data;
      parity_err <= load ? pend_pe : parity_err;
      frame_err  <= load ? (pend_fe || !vote) : frame_err;
      rx_valid   <= complete || (rx_valid && !rx_ready);
      overrun    <= complete && !take;
    end
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Configurable data width, parity and stop bits. Uses an oversampled baud tick with 3-sample majority voting and start-bit validation. Reports parity, framing and overrun errors, and delivers each frame on a valid/ready interface to the downstream command parser or FIFO.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s
OVERSAMPLE, 16, baud ticks per bit; even, minimum 8
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
uart_rxd  input  1  serial line, asynchronous, idle high
rx_data  output  DATA_BITS  received payload, LSB first on line
rx_valid  output  1  rx_data and error flags valid; held until accepted
rx_ready  input  1  downstream accepts when rx_valid && rx_ready
parity_err  output  1  parity mismatch for the held frame; 0 when PARITY = 0
frame_err  output  1  at least one stop bit sampled 0 for the held frame
overrun  output  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset (rst = 1, asynchronous): FSM to IDLE, synchroniser flops to 1, all counters 0, rx_data 0, rx_valid/parity_err/frame_err/overrun 0. Reset mid-frame discards the partial frame.
- uart_rxd passes a 2-flop synchroniser (rxd_s); all logic uses rxd_s.
- Tick generator: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 27 at defaults. One-cycle tick pulse every DIV clocks. The counter is restarted on the IDLE->START transition so sampling is phase-aligned to the edge.
- Sample counter scnt runs 0..OVERSAMPLE-1 on ticks within each bit. Bit value = majority of rxd_s at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1. The value is decided at OVERSAMPLE/2+1.
- FSM states:
  - IDLE: on rxd_s falling edge (prev 1, now 0), go to START.
  - START: at decision point, vote 1 means false start, return to IDLE with nothing reported. Vote 0 continues: at scnt = OVERSAMPLE-1 go to DATA.
  - DATA: shift voted bits LSB first. bcnt counts 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: compare the voted bit with the XOR of the data bits. Odd parity requires an odd number of 1s across data plus parity bit; even requires an even number. A mismatch sets the pending parity error.
  - STOP: vote each stop bit; any 0 sets the pending framing error. At the decision point of the final stop bit, complete the frame. Do not wait for the bit end, to allow resync on early next start.
  - WAIT_HIGH: entered instead of IDLE when the final stop vote is 0 (break or misframe). Stay until rxd_s = 1, then go to IDLE.
- Frame completion, single cycle:
  - If rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data, parity_err, frame_err and set rx_valid = 1.
  - Otherwise: held data and flags are unchanged, the new frame is dropped, overrun = 1 for one cycle.
- Handshake: rx_valid && rx_ready with no completion in that cycle clears rx_valid; rx_data and flags keep their value.
- Latency: rx_valid rises 1 clk after the final stop-bit decision tick.
- A break (line held low) yields one frame with rx_data = 0 and frame_err = 1, then waits in WAIT_HIGH; no repeated frames.

Decomposition:
- Shared package uart_pkg holds:
  - the parity encoding constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state typedef (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - a constant function computing DIV and the counter width from CLK_FREQ/BAUD/OVERSAMPLE. The package is reused by the planned transmitter.
- One sub-module: uart_baud_tick (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst, restart, tick).

Test Plan:
- Defaults (8N1, bit = 432 clk), rx_ready = 1, send 0xA5 -> rx_valid pulses once, rx_data = 0xA5, parity_err = 0, frame_err = 0.
- PARITY = 2, send 0x3C with parity bit 1 (wrong) -> rx_data = 0x3C, parity_err = 1; resend with parity 0 -> parity_err = 0.
- Idle line, 100-clk low glitch -> START entered, returns to IDLE, rx_valid never asserts.
- Send 0x55 with stop bit 0, then hold line low 20 bit times -> exactly one frame, frame_err = 1; next valid frame 0x12 received cleanly after line returns high.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses 1 cycle at the 2nd completion; then rx_ready = 1 -> rx_valid drops.
- Assert rst during DATA bit 4 of 0x5A, release, then send 0x81 -> outputs 0 during reset, next frame rx_data = 0x81 with no stale bits; repeat with DATA_BITS = 7, STOP_BITS = 2.
